// File: rtl/gat_pkg.sv
// Purpose : shared constants, FSM state type and address helper for the GAT feature readback path.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package gat_pkg;

  // Feature BRAM geometry (NUM_SUBGRAPHS * NUM_FEATURE_OUT for CORA).
  localparam int NEW_FEATURE_WIDTH_DFLT  = 32;
  localparam int NEW_FEATURE_DEPTH_DFLT  = 43328;
  localparam int NEW_FEATURE_ADDR_W_DFLT = $clog2(NEW_FEATURE_DEPTH_DFLT);
  localparam int RD_LATENCY_DFLT         = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rdback_state_t;

  // The BRAM port is byte addressed with 32-bit words: word index -> byte address.
  function automatic logic [31:0] word_to_byte(input logic [31:0] word_idx);
    return word_idx << 2;
  endfunction

endpackage

// File: rtl/gat_rdback_fifo.sv
// Purpose : small synchronous skid FIFO holding feature words plus their tlast tag.
// Latency : one cycle from push to visible on the read side; read data is the head entry (show-ahead).
// Backpressure: push is dropped when full (the writer guarantees it never pushes on full); pop ignored when empty.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_dat,     write strobe, data word and its tlast tag
//   push_last
//   pop                 consume the head entry
//   pop_dat, pop_last   head entry (valid only while !empty)
//   count, full, empty  occupancy and flags
module gat_rdback_fifo #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_dat,
  output logic              pop_last,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign {pop_last, pop_dat} = mem[rd_ptr_q];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= {push_last, push_dat};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gat_feat_readback.sv
// Purpose : drains conv2 output features from feature BRAM port B onto a 32-bit AXIS-style stream (tlast on final word).
// Latency : first beat valid RD_LATENCY+1 clocks after the edge that accepts start; 1 word/clock sustained.
// Backpressure: m_tready low stalls the stream; address issue stops once FIFO + in-flight reads fill the skid FIFO.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    begin readback (ignored unless idle)
//   num_words, base_word     transfer length and first word index, sampled on accepted start
//   busy, done               busy from accepted start to last beat accepted; done pulses one cycle afterwards
//   feat_bram_addrb          byte address to BRAM port B (bits[1:0] zero)
//   feat_bram_dout           BRAM read data, valid RD_LATENCY cycles after the address
//   m_tdata/m_tvalid/        output stream
//   m_tready/m_tlast
module gat_feat_readback
  import gat_pkg::*;
#(
  parameter int NEW_FEATURE_WIDTH  = NEW_FEATURE_WIDTH_DFLT,
  parameter int NEW_FEATURE_DEPTH  = NEW_FEATURE_DEPTH_DFLT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int RD_LATENCY         = RD_LATENCY_DFLT,
  parameter int FIFO_DEPTH         = RD_LATENCY + 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
  input  logic [NEW_FEATURE_ADDR_W-1:0] base_word,
  output logic                          busy,
  output logic                          done,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast
);

  localparam int AW           = NEW_FEATURE_ADDR_W;
  localparam int NW           = AW + 1;
  localparam int FIFO_ENTRIES = 1 << $clog2(FIFO_DEPTH);
  localparam int FCW          = $clog2(FIFO_ENTRIES) + 1;
  localparam int OCW          = $clog2(FIFO_ENTRIES + RD_LATENCY + 2) + 1;

  localparam logic [NW-1:0]  DEPTH_N        = NW'(NEW_FEATURE_DEPTH);
  localparam logic [AW-1:0]  LAST_IDX       = AW'(NEW_FEATURE_DEPTH - 1);
  localparam logic [OCW-1:0] FIFO_ENTRIES_O = OCW'(FIFO_ENTRIES);

  typedef logic [RD_LATENCY-1:0] rd_pipe_t;

  rdback_state_t          state_q, state_d;
  logic [NW-1:0]          num_q;
  logic [NW-1:0]          issue_cnt_q;
  logic [NW-1:0]          ret_cnt_q;
  logic [NW-1:0]          num_clamped;
  logic [AW-1:0]          next_word_q;
  logic [AW-1:0]          base_idx;
  logic [AW-1:0]          issue_word;
  logic [AW-1:0]          issue_word_inc;
  logic [AW+1:0]          addrb_q;
  logic                   addr_live_q;
  rd_pipe_t               rd_pipe_q;
  logic                   busy_q;

  logic                   start_ok;
  logic                   first_issue;
  logic                   run_issue;
  logic                   issue_fire;
  logic                   pop_fire;
  logic                   push;
  logic                   push_last;
  logic [OCW-1:0]         inflight;
  logic [OCW-1:0]         occupancy;

  logic [FCW-1:0]               fifo_count;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [NEW_FEATURE_WIDTH-1:0] fifo_dat;
  logic                         fifo_last;

  // ---------------------------------------------------------------------------
  // Start handling and address generation
  // ---------------------------------------------------------------------------
  assign start_ok    = start && (state_q == IDLE);
  assign num_clamped = (num_words > DEPTH_N) ? DEPTH_N : num_words;
  assign base_idx    = (base_word > LAST_IDX) ? '0 : base_word;

  // The first address goes out on the same edge that accepts start, which is what
  // makes the first beat land RD_LATENCY+1 clocks after that edge.
  assign first_issue = start_ok && (num_clamped != '0);
  assign pop_fire    = m_tvalid && m_tready;

  // In-flight reads: the one currently on addrb plus those in the latency pipe.
  always_comb begin
    inflight = OCW'(addr_live_q);
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + OCW'(rd_pipe_q[i]);
    end
  end

  // A pop in this cycle frees a slot, so it counts as credit; without it the
  // issue rule would stall every other cycle at full rate.
  assign occupancy = OCW'(fifo_count) + inflight - OCW'(pop_fire);

  assign run_issue      = (state_q == RUN) && (issue_cnt_q < num_q) && (occupancy < FIFO_ENTRIES_O);
  assign issue_fire     = first_issue || run_issue;
  assign issue_word     = first_issue ? base_idx : next_word_q;
  assign issue_word_inc = (issue_word == LAST_IDX) ? '0 : issue_word + AW'(1);

  // Return side: tlast is decided by the running count of returned words.
  assign push      = rd_pipe_q[RD_LATENCY-1];
  assign push_last = (ret_cnt_q == num_q - NW'(1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_clamped == '0) ? DONE : RUN;
      RUN:     if (issue_cnt_q == num_q) state_d = DRAIN;
      DRAIN:   if (pop_fire && m_tlast) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_q       <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      next_word_q <= '0;
      addrb_q     <= '0;
      addr_live_q <= 1'b0;
      rd_pipe_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_live_q <= issue_fire;
      rd_pipe_q   <= rd_pipe_t'({rd_pipe_q, addr_live_q});

      if (start_ok) begin
        num_q       <= num_clamped;
        ret_cnt_q   <= '0;
        issue_cnt_q <= first_issue ? NW'(1) : '0;
      end else begin
        if (run_issue) begin
          issue_cnt_q <= issue_cnt_q + NW'(1);
        end
        if (push) begin
          ret_cnt_q <= ret_cnt_q + NW'(1);
        end
      end

      if (issue_fire) begin
        addrb_q     <= (AW+2)'(word_to_byte(32'(issue_word)));
        next_word_q <= issue_word_inc;
      end

      // A zero-length request still shows busy for its single DONE cycle.
      if (start_ok) begin
        busy_q <= 1'b1;
      end else if ((state_q == DRAIN && pop_fire && m_tlast) || state_q == DONE) begin
        busy_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid FIFO and stream glue
  // ---------------------------------------------------------------------------
  gat_rdback_fifo #(
    .DATA_W (NEW_FEATURE_WIDTH),
    .DEPTH  (FIFO_ENTRIES)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_dat  (feat_bram_dout),
    .push_last (push_last),
    .pop       (pop_fire),
    .pop_dat   (fifo_dat),
    .pop_last  (fifo_last),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_tvalid        = !fifo_empty;
  assign m_tdata         = fifo_empty ? '0 : fifo_dat;
  assign m_tlast         = !fifo_empty && fifo_last;
  assign feat_bram_addrb = addrb_q;
  assign busy            = busy_q;
  assign done            = (state_q == DONE);

  // The credit rule bounds FIFO + in-flight reads to the FIFO size.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule

// File: tb/tb_gat_feat_readback.sv
module tb_gat_feat_readback;

  localparam int W      = 32;
  localparam int DEPTH  = 43328;
  localparam int AW     = 16;
  localparam int RDL    = 2;
  localparam int FIFO_N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic [AW-1:0] base_word = '0;
  logic          busy;
  logic          done;
  logic [AW+1:0] feat_bram_addrb;
  logic [W-1:0]  feat_bram_dout;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;

  always #5 clk = ~clk;

  gat_feat_readback #(
    .NEW_FEATURE_WIDTH  (W),
    .NEW_FEATURE_DEPTH  (DEPTH),
    .NEW_FEATURE_ADDR_W (AW),
    .RD_LATENCY         (RDL),
    .FIFO_DEPTH         (RDL + 2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .num_words       (num_words),
    .base_word       (base_word),
    .busy            (busy),
    .done            (done),
    .feat_bram_addrb (feat_bram_addrb),
    .feat_bram_dout  (feat_bram_dout),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .m_tlast         (m_tlast)
  );

  // BRAM contents: a unique word per index.
  function automatic logic [31:0] bram_word(input int unsigned idx);
    return (idx * 32'h0001_0001) ^ 32'h5A00_00A5;
  endfunction

  // BRAM port B model with RDL cycles of read latency.
  logic [AW+1:0] apipe [RDL];
  always @(posedge clk) begin
    apipe[0] <= feat_bram_addrb;
    for (int i = 1; i < RDL; i++) apipe[i] <= apipe[i-1];
  end
  assign feat_bram_dout = bram_word(32'(apipe[RDL-1]) >> 2);

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // tready pattern: 0 = always 1, 1 = toggle each cycle, 2 = held low
  int tr_mode = 0;
  always @(posedge clk) begin
    #1;
    case (tr_mode)
      1:       m_tready = ~m_tready;
      2:       m_tready = 1'b0;
      default: m_tready = 1'b1;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and monitors
  logic [32:0]   exp_q[$];
  logic [AW+1:0] addr_log[$];
  logic [32:0]   e;
  int            beat_cnt = 0;
  int            first_vld_cyc = -1;
  int            last_beat_cyc = 0;
  int            start_cyc = 0;
  logic          hold_pending = 1'b0;
  logic [W-1:0]  hold_dat;
  logic          hold_last;

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && (addr_log.size() == 0 || addr_log[$] != feat_bram_addrb))
        addr_log.push_back(feat_bram_addrb);
      if (hold_pending) begin
        chk("hold_vld", m_tvalid, 1);
        chk("hold_dat", m_tdata, hold_dat);
        chk("hold_last", m_tlast, hold_last);
      end
      if (m_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (m_tvalid && m_tready) begin
        chk("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_dat", m_tdata, e[31:0]);
          chk("beat_last", m_tlast, e[32]);
        end
        beat_cnt++;
        if (m_tlast) last_beat_cyc = cyc;
      end
      hold_pending = m_tvalid && !m_tready;
      hold_dat     = m_tdata;
      hold_last    = m_tlast;
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic launch(input int base, input int num);
    int n;
    n = (num > DEPTH) ? DEPTH : num;
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), bram_word((base + i) % DEPTH)});
    addr_log.delete();
    beat_cnt      = 0;
    first_vld_cyc = -1;
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_word = AW'(base);
    num_words = (AW+1)'(num);
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    chk("done_seen", done, 1);
    chk("done_after_last", cyc - last_beat_cyc, 1);
    chk("sb_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_low", busy, 0);
  endtask

  logic [AW+1:0] a0;
  int            popped;
  logic [AW+1:0] t4_addr [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected run completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addrb", feat_bram_addrb, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: 16 words from 0 at full rate
    launch(0, 16);
    wait_done(200);
    chk("t1_latency", first_vld_cyc - start_cyc, RDL + 1);
    chk("t1_beats", beat_cnt, 16);
    chk("t1_naddr", addr_log.size(), 16);
    for (int i = 0; i < 16 && i < addr_log.size(); i++) chk("t1_addr", addr_log[i], i * 4);

    // 2: toggling tready
    tr_mode = 1;
    launch(500, 8);
    wait_done(200);
    tr_mode = 0;
    chk("t2_beats", beat_cnt, 8);

    // 3: zero-length request
    a0 = feat_bram_addrb;
    launch(9, 0);
    @(negedge clk);
    chk("t3_busy", busy, 1);
    chk("t3_done", done, 1);
    chk("t3_tvalid", m_tvalid, 0);
    @(negedge clk);
    chk("t3_busy_end", busy, 0);
    chk("t3_done_end", done, 0);
    repeat (4) @(negedge clk);
    chk("t3_addrb_same", feat_bram_addrb, a0);
    chk("t3_beats", beat_cnt, 0);

    // 4: wrap at the top of the BRAM
    t4_addr[0] = 18'd173304;
    t4_addr[1] = 18'd173308;
    t4_addr[2] = 18'd0;
    t4_addr[3] = 18'd4;
    launch(43326, 4);
    wait_done(200);
    chk("t4_beats", beat_cnt, 4);
    chk("t4_naddr", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("t4_addr", addr_log[i], t4_addr[i]);

    // 5: long stall mid-run, ignored second start
    launch(100, 24);
    for (int i = 0; i < 50 && beat_cnt < 4; i++) @(negedge clk);
    tr_mode = 2;
    repeat (20) @(negedge clk);
    popped = beat_cnt;
    chk("t5_stall_addr", feat_bram_addrb, ((100 + popped + FIFO_N - 1) % DEPTH) * 4);
    chk("t5_tvalid_held", m_tvalid, 1);
    chk("t5_busy", busy, 1);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_word = AW'(5);
    num_words = (AW+1)'(3);
    @(posedge clk);
    #1 start = 1'b0;
    tr_mode = 0;
    wait_done(300);
    chk("t5_beats", beat_cnt, 24);

    // 6: asynchronous reset mid-run, then a fresh short run
    launch(200, 30);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_tvalid", m_tvalid, 0);
    chk("t6_tlast", m_tlast, 0);
    chk("t6_tdata", m_tdata, 0);
    chk("t6_addrb", feat_bram_addrb, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    launch(7, 2);
    wait_done(200);
    chk("t6_beats", beat_cnt, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
